// File: rtl/hazard_pkg.sv
// Shared opcodes, EX-stage tracker record and FSM state type for the hazard controller.
package hazard_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr_en;
    logic       is_load;
  } stage_info_t;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} haz_state_t;

endpackage

// File: rtl/hazard_decode.sv
// Combinational ID-stage decode: register fields, source usage, writeback info and EX select hints.
import hazard_pkg::*;

module hazard_decode (
  input  logic [31:0] instr,
  output logic        known,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        wr_en,
  output logic        is_load,
  output logic        a2_sel,
  output logic        b2_sel,
  output logic        br_un
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       writes;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign rd          = instr[11:7];
  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign unused_bits = ^{instr[31:25], funct3[2], funct3[0]};

  always_comb begin
    known   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    writes  = 1'b0;
    is_load = 1'b0;
    a2_sel  = 1'b0;
    b2_sel  = 1'b0;
    br_un   = 1'b0;
    case (opcode)
      OP:     begin known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; writes = 1'b1; end
      OP_IMM: begin known = 1'b1; use_rs1 = 1'b1; writes = 1'b1; b2_sel = 1'b1; end
      LOAD:   begin known = 1'b1; use_rs1 = 1'b1; writes = 1'b1; is_load = 1'b1; b2_sel = 1'b1; end
      STORE:  begin known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; b2_sel = 1'b1; end
      BRANCH: begin
        known   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        a2_sel  = 1'b1;
        b2_sel  = 1'b1;
        br_un   = funct3[1];
      end
      JAL:    begin known = 1'b1; writes = 1'b1; a2_sel = 1'b1; b2_sel = 1'b1; end
      JALR:   begin known = 1'b1; use_rs1 = 1'b1; writes = 1'b1; b2_sel = 1'b1; end
      LUI:    begin known = 1'b1; writes = 1'b1; b2_sel = 1'b1; end
      AUIPC:  begin known = 1'b1; writes = 1'b1; a2_sel = 1'b1; b2_sel = 1'b1; end
      default: known = 1'b0;
    endcase
  end

  // x0 is never a forwarding or load-use source
  assign wr_en = writes & (rd != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding control: EX-aligned selects, load-use stall, taken-branch squash.
// Optional perf counters when HAZ_PERF_CNT_EN is defined.
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int BR_PENALTY = 2,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_i,
  input  logic              instr_valid_i,
  input  logic              branch_taken_i,
  output logic              A1_sel_o,
  output logic              B1_sel_o,
  output logic              A2_sel_o,
  output logic              B2_sel_o,
  output logic              BrUn_o,
  output logic              ex_valid_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  logic        known, use_rs1, use_rs2, wr_en, is_load, a2_sel, b2_sel, br_un;
  logic [4:0]  rs1, rs2, rd;
  haz_state_t  state;
  logic [1:0]  pen_cnt;
  stage_info_t ex_q, mem_q;
  logic        load_use, stall, flush, issue, fwd_a, fwd_b;
  logic        unused_mem;

  hazard_decode u_decode (
    .instr   (instr_i),
    .known   (known),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .wr_en   (wr_en),
    .is_load (is_load),
    .a2_sel  (a2_sel),
    .b2_sel  (b2_sel),
    .br_un   (br_un)
  );

  always_comb begin
    load_use = (state == RUN) & instr_valid_i & known & ex_q.valid & ex_q.is_load & ex_q.wr_en &
               ((use_rs1 & (rs1 == ex_q.rd)) | (use_rs2 & (rs2 == ex_q.rd)));
    flush    = !rst & (branch_taken_i | (state == FLUSH));
    stall    = !rst & load_use & !branch_taken_i;
    issue    = instr_valid_i & known & !flush & !stall;
    fwd_a    = issue & use_rs1 & ex_q.valid & ex_q.wr_en & !ex_q.is_load & (ex_q.rd == rs1);
    fwd_b    = issue & use_rs2 & ex_q.valid & ex_q.wr_en & !ex_q.is_load & (ex_q.rd == rs2);
  end

  assign stall_o    = stall;
  assign flush_o    = flush;
  assign ex_valid_o = ex_q.valid;
  // MEM-stage record is kept for observability; forwarding only needs the EX record
  assign unused_mem = ^mem_q;

  // ID -> EX boundary: trackers, registered selects and FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pen_cnt  <= 2'd0;
      ex_q     <= '0;
      mem_q    <= '0;
      A1_sel_o <= 1'b0;
      B1_sel_o <= 1'b0;
      A2_sel_o <= 1'b0;
      B2_sel_o <= 1'b0;
      BrUn_o   <= 1'b0;
    end else begin
      mem_q    <= ex_q;
      ex_q     <= issue ? '{valid: 1'b1, rd: rd, wr_en: wr_en, is_load: is_load} : '0;
      A1_sel_o <= fwd_a;
      B1_sel_o <= fwd_b;
      A2_sel_o <= issue & a2_sel;
      B2_sel_o <= issue & b2_sel;
      BrUn_o   <= issue & br_un;
      if (branch_taken_i) begin
        pen_cnt <= 2'(BR_PENALTY - 1);
        state   <= (BR_PENALTY > 1) ? FLUSH : RUN;
      end else begin
        case (state)
          RUN:     if (stall) state <= STALL;
          STALL:   state <= RUN;
          FLUSH: begin
            pen_cnt <= pen_cnt - 2'd1;
            if (pen_cnt <= 2'd1) state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Flush takes precedence when both are reported in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (flush) begin
      flush_cnt_o <= flush_cnt_o + 1'b1;
    end else if (stall) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
